// File: rtl/flag_read_unit.sv
// flag_read_unit: forwards carry/zero to decode from EX and a shadow pipeline of in-flight flag writes,
// evaluates the decode flag condition and stalls on an unresolved late (load-type) zero.
module flag_read_unit #(
  parameter int STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arch_carry,
  input  logic       arch_zero,
  input  logic       ex_valid,
  input  logic       ex_carry_wr,
  input  logic       ex_zero_wr,
  input  logic       ex_carry,
  input  logic       ex_zero,
  input  logic       ex_zero_late,
  input  logic       mem_zero_valid,
  input  logic       mem_zero,
  input  logic       pipe_stall,
  input  logic       flush_ex,
  input  logic       rd_req,
  input  logic [1:0] rd_cond,
  output logic       carry_fwd,
  output logic       zero_fwd,
  output logic       rd_exec,
  output logic       rd_stall
);
  logic [STAGES-1:0] v_q, cw_q, zw_q, c_q, z_q, zp_q;
  logic [STAGES-1:0] v_d, cw_d, zw_d, c_d, z_d, zp_d;
  logic [STAGES-1:0] zr, zpr;
  logic ex_v, z_unres, cond_ok;
  assign ex_v = ex_valid & ~flush_ex;
  // slot 0 as seen after this cycle's late-zero resolution
  always_comb begin
    zr = z_q;
    zpr = zp_q;
    zr[0] = (zp_q[0] & mem_zero_valid) ? mem_zero : z_q[0];
    zpr[0] = zp_q[0] & ~mem_zero_valid;
  end
  always_comb begin
    v_d = v_q;
    cw_d = cw_q;
    zw_d = zw_q;
    c_d = c_q;
    z_d = zr;
    zp_d = zpr;
    if (!pipe_stall) begin
      for (int i = STAGES - 1; i > 0; i--) begin
        v_d[i] = v_q[i-1];
        cw_d[i] = cw_q[i-1];
        zw_d[i] = zw_q[i-1];
        c_d[i] = c_q[i-1];
        z_d[i] = zr[i-1];
        zp_d[i] = zpr[i-1];
      end
      v_d[0] = ex_v;
      cw_d[0] = ex_v & ex_carry_wr;
      zw_d[0] = ex_v & ex_zero_wr;
      c_d[0] = ex_carry;
      z_d[0] = ex_zero;
      zp_d[0] = ex_v & ex_zero_late & ex_zero_wr;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      cw_q <= '0;
      zw_q <= '0;
      c_q <= '0;
      z_q <= '0;
      zp_q <= '0;
    end else begin
      v_q <= v_d;
      cw_q <= cw_d;
      zw_q <= zw_d;
      c_q <= c_d;
      z_q <= z_d;
      zp_q <= zp_d;
    end
  end
  // oldest to youngest so the youngest qualifying writer wins
  always_comb begin
    carry_fwd = arch_carry;
    zero_fwd = arch_zero;
    z_unres = 1'b0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (v_q[i] & cw_q[i]) carry_fwd = c_q[i];
      if (v_q[i] & zw_q[i]) begin
        zero_fwd = zr[i];
        z_unres = (i == 0) ? zpr[0] : 1'b0;
      end
    end
    if (ex_v & ex_carry_wr) carry_fwd = ex_carry;
    if (ex_v & ex_zero_wr) begin
      zero_fwd = ex_zero & ~ex_zero_late;
      z_unres = ex_zero_late;
    end
  end
  assign cond_ok = rd_cond[1] ? (rd_cond[0] ? ~carry_fwd & ~zero_fwd : zero_fwd)
                              : (rd_cond[0] ? carry_fwd : 1'b1);
  assign rd_stall = rd_req & rd_cond[1] & z_unres;
  assign rd_exec = ~rd_stall & cond_ok;
  for (genvar g = 1; g < STAGES; g++) begin : g_chk
    always @(posedge clk) if (!rst) assert (!zp_q[g]) else $error("late zero left slot 0 unresolved");
  end
endmodule

// File: tb/tb_flag_read_unit.sv
// tb_flag_read_unit: directed vectors for the combinational paths plus sequences for the shadow pipeline.
module tb_flag_read_unit;
  logic clk = 0, rst = 1;
  logic arch_carry, arch_zero, ex_valid, ex_carry_wr, ex_zero_wr, ex_carry, ex_zero, ex_zero_late;
  logic mem_zero_valid, mem_zero, pipe_stall, flush_ex, rd_req;
  logic [1:0] rd_cond;
  logic carry_fwd, zero_fwd, rd_exec, rd_stall;
  int checks = 0, failures = 0;

  flag_read_unit #(.STAGES(2)) dut (
    .clk(clk), .rst(rst), .arch_carry(arch_carry), .arch_zero(arch_zero),
    .ex_valid(ex_valid), .ex_carry_wr(ex_carry_wr), .ex_zero_wr(ex_zero_wr),
    .ex_carry(ex_carry), .ex_zero(ex_zero), .ex_zero_late(ex_zero_late),
    .mem_zero_valid(mem_zero_valid), .mem_zero(mem_zero), .pipe_stall(pipe_stall),
    .flush_ex(flush_ex), .rd_req(rd_req), .rd_cond(rd_cond),
    .carry_fwd(carry_fwd), .zero_fwd(zero_fwd), .rd_exec(rd_exec), .rd_stall(rd_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ac, az, exv, fl, cwr, c, zwr, z, zl, req;
    logic [1:0] cond;
    logic cf, zf, ex, st;
  } vec_t;
  vec_t tv[14];

  task automatic chk(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic chk4(input string name, input logic cf, input logic zf, input logic ex, input logic st);
    chk({name, ".carry_fwd"}, carry_fwd, cf);
    chk({name, ".zero_fwd"}, zero_fwd, zf);
    chk({name, ".rd_exec"}, rd_exec, ex);
    chk({name, ".rd_stall"}, rd_stall, st);
  endtask

  task automatic idle_ex();
    ex_valid = 0; ex_carry_wr = 0; ex_zero_wr = 0; ex_carry = 0; ex_zero = 0;
    ex_zero_late = 0; flush_ex = 0; mem_zero_valid = 0; mem_zero = 0;
  endtask

  // drive on the falling edge, sample 2 ns later, well clear of the rising edge
  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    //        ac az exv fl cwr c zwr z zl req cond   cf zf ex st
    tv[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 1, 0, 1, 0};
    tv[1]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 1, 0, 0, 0};
    tv[2]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 1, 1, 0};
    tv[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b11, 0, 0, 1, 0};
    tv[4]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b11, 1, 0, 0, 0};
    tv[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, 1, 0};
    tv[6]  = '{0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 2'b01, 1, 0, 1, 0};
    tv[7]  = '{1, 0, 1, 1, 1, 0, 0, 0, 0, 1, 2'b01, 1, 0, 1, 0};
    tv[8]  = '{1, 0, 1, 0, 0, 0, 1, 1, 0, 1, 2'b10, 1, 1, 1, 0};
    tv[9]  = '{0, 0, 1, 0, 0, 0, 1, 0, 1, 1, 2'b10, 0, 0, 0, 1};
    tv[10] = '{1, 0, 1, 0, 0, 0, 1, 0, 1, 1, 2'b01, 1, 0, 1, 0};
    tv[11] = '{0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 2'b10, 0, 0, 0, 0};
    tv[12] = '{0, 0, 1, 0, 0, 0, 1, 0, 1, 1, 2'b11, 0, 0, 0, 1};
    tv[13] = '{0, 0, 1, 1, 0, 0, 1, 0, 1, 1, 2'b10, 0, 0, 0, 0};

    idle_ex();
    arch_carry = 1; arch_zero = 1; pipe_stall = 0; rd_req = 1; rd_cond = 2'b10;
    repeat (2) nxt();
    #2 chk4("reset", 1, 1, 1, 0);
    nxt(); rst = 0;

    // EX-level and arch-level combinational vectors; pipe frozen so slots stay empty
    pipe_stall = 1;
    for (int i = 0; i < 14; i++) begin
      nxt();
      arch_carry = tv[i].ac; arch_zero = tv[i].az; ex_valid = tv[i].exv; flush_ex = tv[i].fl;
      ex_carry_wr = tv[i].cwr; ex_carry = tv[i].c; ex_zero_wr = tv[i].zwr; ex_zero = tv[i].z;
      ex_zero_late = tv[i].zl; rd_req = tv[i].req; rd_cond = tv[i].cond;
      #2 chk4($sformatf("vec%0d", i), tv[i].cf, tv[i].zf, tv[i].ex, tv[i].st);
    end

    // EX beats s[0]; entry drains after STAGES edges
    nxt(); idle_ex(); pipe_stall = 0; arch_carry = 1; arch_zero = 0; rd_req = 1; rd_cond = 2'b01;
    ex_valid = 1; ex_carry_wr = 1; ex_carry = 1;
    nxt(); ex_carry = 0;
    #2 chk("ex_over_s0", carry_fwd, 0);
    chk("ex_over_s0.exec", rd_exec, 0);
    nxt(); idle_ex();
    #2 chk("s0_carry", carry_fwd, 0);
    nxt();
    #2 chk("s1_carry", carry_fwd, 0);
    nxt(); nxt();
    #2 chk("carry_drained", carry_fwd, 1);

    // late zero resolved the following cycle
    nxt(); arch_zero = 0; rd_cond = 2'b10;
    ex_valid = 1; ex_zero_wr = 1; ex_zero_late = 1;
    #2 chk("load_ex.stall", rd_stall, 1);
    nxt(); idle_ex(); mem_zero_valid = 1; mem_zero = 1;
    #2 chk4("load_resolved", 1, 1, 1, 0);
    nxt(); idle_ex();
    #2 chk("load_in_s1.zero", zero_fwd, 1);
    repeat (2) nxt();

    // late zero held under pipe_stall, resolved in place, then shifted
    arch_zero = 1;
    ex_valid = 1; ex_zero_wr = 1; ex_zero_late = 1;
    nxt(); idle_ex(); pipe_stall = 1;
    for (int i = 0; i < 3; i++) begin
      #2 chk($sformatf("held_load%0d.stall", i), rd_stall, 1);
      nxt();
    end
    mem_zero_valid = 1; mem_zero = 0;
    #2 chk4("held_resolve", 1, 0, 0, 0);
    nxt(); mem_zero_valid = 0; pipe_stall = 0;
    #2 chk("held_inplace.zero", zero_fwd, 0);
    chk("held_inplace.stall", rd_stall, 0);
    nxt();
    #2 chk("held_shifted.zero", zero_fwd, 0);
    repeat (2) nxt();

    // flushed EX carry write is neither forwarded nor captured
    arch_carry = 1; rd_cond = 2'b01;
    ex_valid = 1; ex_carry_wr = 1; ex_carry = 0; flush_ex = 1;
    #2 chk("flush.carry", carry_fwd, 1);
    nxt(); idle_ex();
    #2 chk("flush_s0.carry", carry_fwd, 1);

    // async reset with two live slots, one of them a pending zero
    nxt(); arch_carry = 1; arch_zero = 0; rd_cond = 2'b10;
    ex_valid = 1; ex_carry_wr = 1; ex_carry = 0;
    nxt(); ex_carry_wr = 0; ex_zero_wr = 1; ex_zero_late = 1;
    nxt(); idle_ex();
    #2 chk("pre_rst.carry", carry_fwd, 0);
    chk("pre_rst.stall", rd_stall, 1);
    rst = 1;
    #1 chk4("async_rst", 1, 0, 0, 0);
    nxt(); rst = 0;
    nxt();
    #2 chk("post_rst.carry", carry_fwd, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/flag_read_unit.md
Name: flag_read_unit

Overview:
- Consumer-side counterpart of the carry/zero flag register. It supplies the correct carry and zero values to the instruction currently in decode.
- It also evaluates that instruction's flag condition (e.g. ADC/ADZ-style conditional execution and Z-based branches).
- It keeps a shadow pipeline of in-flight flag writes so consumers do not wait for writeback commit. It forwards the youngest pending value and raises a stall only when a zero flag is not yet resolved (load-type producers).

Parameters:
- STAGES, 2, number of shadow slots between the EX capture point and flag-register commit (MEM..WB); legal range 1..4.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- arch_carry  input  1  committed carry from the flag register
- arch_zero  input  1  committed zero from the flag register
- ex_valid  input  1  EX holds a real (non-bubble) instruction
- ex_carry_wr  input  1  EX instruction writes carry
- ex_zero_wr  input  1  EX instruction writes zero
- ex_carry  input  1  carry result from EX
- ex_zero  input  1  zero result from EX; ignored when ex_zero_late=1
- ex_zero_late  input  1  zero is only known in MEM (load-type producer)
- mem_zero_valid  input  1  late zero for slot 0 is available this cycle
- mem_zero  input  1  late zero value
- pipe_stall  input  1  pipeline frozen; no capture, no advance
- flush_ex  input  1  squash the EX instruction; it is not captured
- rd_req  input  1  decode instruction consumes flags
- rd_cond  input  2  00 always, 01 if C=1, 10 if Z=1, 11 if C=0 and Z=0
- carry_fwd  output  1  forwarded carry
- zero_fwd  output  1  forwarded zero
- rd_exec  output  1  condition satisfied (valid when rd_stall=0)
- rd_stall  output  1  decode must hold; flag not yet resolved

Behaviour:
- Slot state: each slot s[i], i=0..STAGES-1, holds v, cw, zw, c, z, zp (zero pending). s[0] is youngest (MEM).
- Reset: all slot fields clear asynchronously. With slots empty and ex_valid=0, carry_fwd=arch_carry, zero_fwd=arch_zero, rd_stall=0, and rd_exec follows rd_cond from the arch values.
- Advance (posedge, pipe_stall=0):
  - s[i+1] <= s[i].
  - s[0] <= EX capture. v=ex_valid & ~flush_ex. cw/zw are gated by v. c=ex_carry. z=ex_zero. zp=ex_zero_late & ex_zero_wr.
  - If s[0].zp=1 and mem_zero_valid=1, the value advancing into s[1] has z=mem_zero and zp=0.
  - The last slot retires (the flag register commits it via WB).
- Hold (pipe_stall=1): no shift. mem_zero_valid still resolves s[0] in place: z<=mem_zero, zp<=0.
- Carry forwarding is combinational, same cycle. Priority: EX (ex_valid & ~flush_ex & ex_carry_wr) > s[0] > ... > s[STAGES-1] > arch_carry. A level qualifies only if v & cw (EX level uses the condition above).
- Zero forwarding uses the same priority with zw.
  - EX level with ex_zero_late=1 is unresolved.
  - s[0] with zp=1 resolves to mem_zero if mem_zero_valid=1; otherwise it is unresolved.
  - A slot at i>=1 never has zp=1. If one does, that is a design error; flag it with an assertion.
- rd_stall = rd_req & rd_cond[1] & (youngest zero source unresolved).
  - rd_cond 01 never stalls.
  - rd_cond 11 stalls if Z is unresolved.
  - rd_stall=0 when rd_req=0.
- rd_exec is combinational from the forwarded values. It is held at 0 while rd_stall=1.
- Simultaneous events:
  - flush_ex with pipe_stall=1: no capture occurs anyway. The EX entry is excluded from forwarding in that cycle.
  - EX and s[0] both write carry: EX wins.
- Reset mid-operation: all in-flight entries are dropped immediately and the outputs fall back to the arch values.
- No combinational path exists from rd_* to any slot register.

Test Plan:
- Reset, then arch_carry=1, arch_zero=0, rd_req=1, rd_cond=01 -> carry_fwd=1, rd_exec=1, rd_stall=0. Same with rd_cond=10 -> rd_exec=0.
- EX writes carry=0 while s[0] holds carry=1 and arch_carry=1 -> carry_fwd=0 in the same cycle. Next cycle (EX empty) s[0]=0 -> still 0. After STAGES+1 cycles without commit -> arch value 1.
- Load in EX with ex_zero_late=1, ex_zero_wr=1; rd_cond=10 -> rd_stall=1 that cycle. Next cycle mem_zero_valid=1, mem_zero=1 -> rd_stall=0, zero_fwd=1, rd_exec=1.
- Same load with mem_zero_valid held 0 and pipe_stall=1 for 3 cycles -> rd_stall stays 1. Then mem_zero_valid=1, mem_zero=0 -> rd_stall=0, rd_exec=0. The slot keeps z=0 after the shift.
- flush_ex=1 on an EX carry write of 0, arch_carry=1 -> carry_fwd=1. The next cycle s[0].v=0.
- Assert rst asynchronously mid-stream with 2 valid slots -> outputs revert to the arch values before the next clock edge, and rd_stall=0.
